binary_to_xs3_seq: RTL and testbench

Sequential, parametrised binary-to-decimal converter using the shift-and-add-3 (double-dabble) method, one input bit per clock. Output is either packed BCD or packed excess-3, selected per conversion. Out-of-range detection replaces the old combinational excess-3 converter's tri-state output with an explicit overflow flag. Sits between binary datapath results and display/decimal-interface logic.

---
 rtl/binary_to_xs3_seq.sv | 112 +++++++++++
 tb/tb_binary_to_xs3_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/binary_to_xs3_seq.sv
// Sequential shift-and-add-3 binary-to-decimal converter, one input bit per clock.
// Result is packed BCD or packed excess-3 (selected per conversion), with an exact overflow flag.
module binary_to_xs3_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  state_t          state, next_state;
  logic [WIDTH-1:0] shift_q;
  logic [DW-1:0]   digits_q;
  logic [DW-1:0]   adj;
  logic [DW-1:0]   res_next;
  logic [CW-1:0]   cnt;
  logic            sticky;
  logic            mode_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; CONV spends one extra cycle with cnt==0 to form the result
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)      next_state = CONV;
      CONV:    if (cnt == '0)  next_state = FINISH;
      FINISH:                  next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Per-digit add-3 correction applied before each shift
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      else                            adj[4*i +: 4] = digits_q[4*i +: 4];
    end
  end

  // Output formatting: saturated all-ones on overflow, otherwise BCD or excess-3
  always_comb begin
    res_next = '0;
    if (sticky) begin
      res_next = '1;
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (mode_q) res_next[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
        else        res_next[4*i +: 4] = digits_q[4*i +: 4];
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      digits_q <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      busy <= (next_state == CONV);
      done <= (next_state == FINISH);
      unique case (state)
        IDLE: begin
          if (start) begin
            shift_q  <= bin_in;
            digits_q <= '0;
            sticky   <= 1'b0;
            mode_q   <= mode;
            cnt      <= CW'(WIDTH);
          end
        end
        CONV: begin
          if (cnt != '0) begin
            digits_q <= {adj[DW-2:0], shift_q[WIDTH-1]};
            shift_q  <= {shift_q[WIDTH-2:0], 1'b0};
            if (adj[DW-1]) sticky <= 1'b1;
            cnt      <= cnt - 1'b1;
          end else begin
            result <= res_next;
            ovf    <= sticky;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_xs3_seq.sv
// Directed bench for binary_to_xs3_seq: default 3-digit instance and a 2-digit instance
// for the overflow boundary, with hand-computed expected results.
module tb_binary_to_xs3_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start3 = 1'b0;
  logic        start2 = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy3, done3, ovf3;
  logic        busy2, done2, ovf2;
  logic [11:0] result3;
  logic [7:0]  result2;
  logic [11:0] last3 = '0;
  logic [11:0] last2 = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  binary_to_xs3_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .bin_in(bin),
    .busy(busy3), .done(done3), .result(result3), .ovf(ovf3)
  );

  binary_to_xs3_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .bin_in(bin),
    .busy(busy2), .done(done2), .result(result2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic convert(input int sel, input logic [7:0] b, input logic m,
                         input logic [11:0] exp_res, input logic exp_ovf, input string tag);
    int          busy_n;
    bit          seen;
    logic [11:0] hold;
    logic        d, bz, o;
    logic [11:0] r;
    hold = (sel == 0) ? last3 : last2;
    busy_n = 0;
    seen = 1'b0;
    @(negedge clk);
    bin  = b;
    mode = m;
    if (sel == 0) start3 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    start2 = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      d  = (sel == 0) ? done3 : done2;
      bz = (sel == 0) ? busy3 : busy2;
      o  = (sel == 0) ? ovf3  : ovf2;
      r  = (sel == 0) ? result3 : {4'h0, result2};
      if (k == 5) check({tag, "_hold"}, 32'(r), 32'(hold));
      if (d) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(k), 32'd10);
        check({tag, "_result"}, 32'(r), 32'(exp_res));
        check({tag, "_ovf"}, 32'(o), 32'(exp_ovf));
      end else if (bz) begin
        busy_n++;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
    @(negedge clk);
    d = (sel == 0) ? done3 : done2;
    check({tag, "_done_pulse"}, 32'(d), 32'd0);
    if (sel == 0) last3 = exp_res; else last2 = exp_res;
  endtask

  initial begin
    int dones;
    #12;
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_result", 32'(result3), 32'd0);
    check("rst_ovf", 32'(ovf3), 32'd0);
    check("rst_result2", 32'(result2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    convert(0, 8'd0,   1'b0, 12'h000, 1'b0, "zero");
    convert(0, 8'd255, 1'b1, 12'h588, 1'b0, "max_xs3");
    convert(0, 8'd255, 1'b0, 12'h255, 1'b0, "max_bcd");
    convert(0, 8'd159, 1'b0, 12'h159, 1'b0, "v159");
    convert(0, 8'd9,   1'b1, 12'h33C, 1'b0, "v9_xs3");
    convert(1, 8'd99,  1'b0, 12'h099, 1'b0, "d2_99");
    convert(1, 8'd100, 1'b0, 12'h0FF, 1'b1, "d2_100");
    convert(1, 8'd50,  1'b1, 12'h083, 1'b0, "d2_50_xs3");
    convert(1, 8'd100, 1'b1, 12'h0FF, 1'b1, "d2_100_xs3");
    convert(1, 8'd255, 1'b0, 12'h0FF, 1'b1, "d2_255");

    // Start held high, operand and mode churn during the conversion
    @(negedge clk);
    bin = 8'd42;
    mode = 1'b0;
    start3 = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done3) begin
        dones++;
        check("held_result", 32'(result3), 32'h042);
        check("held_latency", 32'(k), 32'd10);
      end
      if (k == 11) begin
        check("held_no_relaunch_busy", 32'(busy3), 32'd0);
        check("held_no_relaunch_done", 32'(done3), 32'd0);
      end
      bin  = 8'($urandom);
      mode = ~mode;
    end
    start3 = 1'b0;
    check("held_done_count", 32'(dones), 32'd1);
    last3 = 12'h042;

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    bin = 8'd200;
    mode = 1'b0;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy3), 32'd0);
    check("arst_done", 32'(done3), 32'd0);
    check("arst_result", 32'(result3), 32'd0);
    check("arst_ovf", 32'(ovf3), 32'd0);
    last3 = '0;
    last2 = '0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done3) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);
    convert(0, 8'd7, 1'b1, 12'h33A, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
